fb_port_arbiter: RTL
====================

# fb_port_arbiter

Shares the single-port framebuffer RAM between VGA scanout reads and coprocessor pixel writes. Scanout has absolute priority inside the image window. Writes are buffered in a small FIFO and drained on free cycles. Sits between `vga_controller` (x_vga/y_vga/hsync/vsync/flow_enabled) and the framebuffer RAM. It delays sync and enable by the read latency so the pixel stream stays aligned.

## Interface
- `IMG_W`, 160: image width in pixels
- `IMG_H`, 120: image height in lines
- `X_OFF`, 240: first visible column of the image
- `Y_OFF`, 180: first visible line of the image
- `PIX_W`, 8: pixel width
- `ADDR_W`, 15: framebuffer address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- `WQ_DEPTH`, 4: write FIFO depth (power of 2)
- `BG_COLOR`, 0: pixel driven inside the visible area but outside the image

Ports:
- `clk`  in  1  pixel clock (25 MHz). Single clock domain.
- `reset`  in  1  synchronous, active-high
- `x_vga`, `y_vga`  in  10 each  raster position from the timing generator
- `hsync`, `vsync`, `flow_enabled`  in  1 each  raw timing signals
- `vblank_only`  in  1  1 = drain writes only while y_vga ≥ 480
- `wr_valid`  in  1  coprocessor write request
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  PIX_W  write data
- `wr_ready`  out  1  FIFO can accept an entry
- `mem_addr`  out  ADDR_W  RAM address (registered)
- `mem_we`  out  1  RAM write enable (registered)
- `mem_wdata`  out  PIX_W  RAM write data (registered)
- `mem_rdata`  in  PIX_W  RAM read data; the RAM has 1-cycle synchronous read
- `pixel_out`  out  PIX_W  pixel aligned with the delayed syncs
- `hsync_out`, `vsync_out`, `de_out`  out  1 each  timing inputs delayed 3 cycles

## Operation
- Display request in cycle t: `disp_req` = flow_enabled ∧ X_OFF ≤ x_vga < X_OFF+IMG_W ∧ Y_OFF ≤ y_vga < Y_OFF+IMG_H.
- Read address = (y_vga−Y_OFF)*IMG_W + (x_vga−X_OFF). It may be computed by multiply or by a running counter, but the value must be exact.
- Port grant for cycle t, registered at the end of t:
  - If disp_req: mem_addr ← read address, mem_we ← 0.
  - Else if FIFO is non-empty and (vblank_only = 0 or y_vga ≥ 480): mem_addr/mem_wdata ← FIFO head, mem_we ← 1, pop the FIFO.
  - Else: mem_we ← 0; mem_addr and mem_wdata hold their values.
- Write FIFO behaviour:
  - A push happens when wr_valid ∧ wr_ready.
  - wr_ready = ¬full ∧ ¬reset. When full, wr_ready is 0 even in a cycle that pops.
  - A push and a pop in the same cycle are both performed; the count is unchanged.
  - Entries drain strictly in order.
  - wr_addr ≥ IMG_W*IMG_H is written anyway; range checking is the coprocessor's responsibility.
- RAM collisions: a read and a write never occur in the same cycle. A write to a pixel on the current line is visible only if it lands before that pixel's read cycle.
- Output pixel selection, on the delayed flags:
  - de = 0: pixel_out = 0.
  - de = 1, outside the image window: pixel_out = BG_COLOR.
  - de = 1, inside the window: pixel_out = mem_rdata.
- Write starvation is bounded: at most IMG_W consecutive cycles per line are display reads.
- Reset values, applied in the cycle after reset is sampled high:
  - mem_addr 0, mem_we 0, mem_wdata 0
  - pixel_out 0, de_out 0
  - hsync_out 1, vsync_out 1
  - FIFO empty
- Reset mid-operation drops all queued writes. No partial write is issued after reset.

## Timing
- Read pipeline, fixed 3 cycles:
  - cycle t: inputs sampled
  - t+1: mem_addr valid
  - t+2: mem_rdata valid
  - t+3: pixel_out registered
- hsync_out/vsync_out/de_out and the window flag pass through a matching 3-stage shift register.
- Write latency: a push in cycle t with the FIFO empty and the port free makes mem_we = 1 in cycle t+2 (push at end of t, grant at end of t+1).
- FIFO status: full and empty are derived from a registered count. wr_ready updates one cycle after the push that fills the FIFO.

## Structure
- Shared package `vga_pkg`:
  - H_PIXELS=640, H_FRONT=16, H_SYNC=96, H_BACK=48, H_TOTAL=800
  - V_PIXELS=480, V_FRONT=10, V_SYNC=2, V_BACK=33, V_TOTAL=525
  - This block uses V_PIXELS for the vblank test.
- Sub-module `wr_fifo`: a parameterised synchronous FIFO (width ADDR_W+PIX_W, depth WQ_DEPTH) with push, pop, full, empty and count.
- The grant logic, the address calculation and the 3-stage alignment pipeline stay in the top module.

## Test plan
- Scanout: preload RAM[k]=k[7:0], drive a full frame.
  - Required: at x=240,y=180 (appearing 3 cycles later), pixel_out=0x00, de_out=1.
  - x=399,y=180 → 0x9F (159); x=240,y=181 → 0xA0 (160); x=100,y=50 → BG_COLOR.
- Write during window: push addr 5, data 0xAA at x_vga=250, y_vga=200.
  - Required: mem_we stays 0 until the window ends; mem_we=1 with mem_addr=5 in the cycle after x_vga=400.
  - The FIFO must not be popped during the window.
- FIFO full: hold wr_valid with the port blocked for 6 cycles.
  - Required: exactly 4 accepted; wr_ready=0 from the cycle after the 4th push.
  - The entries then drain in order, one per free cycle.
- vblank_only=1: push 3 writes at y_vga=300 (outside the window).
  - Required: no mem_we until y_vga=480; then 3 consecutive writes.
- Reset mid-drain: assert reset for 1 cycle with 3 entries queued.
  - Required: the next cycle has mem_we=0, hsync_out=1, vsync_out=1, de_out=0, pixel_out=0 and the FIFO empty.
  - wr_ready=1 afterwards, and no stale writes are issued.
- Sync alignment: over a full frame, check hsync_out(t) = hsync(t−3), vsync_out(t) = vsync(t−3) and de_out(t) = flow_enabled(t−3).

Source files
------------

// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants shared by the display pipeline blocks.
package vga_pkg;

  localparam int unsigned H_PIXELS = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = 800;

  localparam int unsigned V_PIXELS = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = 525;

  // True when lo <= v < lo + len.
  function automatic logic in_range(input logic [9:0] v, input int unsigned lo,
                                    input int unsigned len);
    return (32'(v) >= lo) && (32'(v) < lo + len);
  endfunction

endpackage

// File: rtl/wr_fifo.sv
// Synchronous FIFO with registered occupancy count; Depth must be a power of two.
module wr_fifo #(
  parameter int unsigned Width = 23,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  assign head  = mem_q[rptr_q];
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scanout reads win inside the image window, queued
// coprocessor writes drain on free cycles; timing signals are delayed to match read latency.
module fb_port_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned       IMG_W    = 160,
  parameter int unsigned       IMG_H    = 120,
  parameter int unsigned       X_OFF    = 240,
  parameter int unsigned       Y_OFF    = 180,
  parameter int unsigned       PIX_W    = 8,
  parameter int unsigned       ADDR_W   = 15,
  parameter int unsigned       WQ_DEPTH = 4,
  parameter logic [PIX_W-1:0]  BG_COLOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x_vga,
  input  logic [9:0]        y_vga,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              flow_enabled,
  input  logic              vblank_only,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              de_out
);

  localparam int unsigned EntW = ADDR_W + PIX_W;
  localparam int unsigned CntW = $clog2(WQ_DEPTH) + 1;

  logic              in_win, disp_req, drain_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [EntW-1:0]   fifo_head;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic [2:0]        hs_q, vs_q, de_q;
  logic [1:0]        win_q;

  assign in_win   = in_range(x_vga, X_OFF, IMG_W) && in_range(y_vga, Y_OFF, IMG_H);
  assign disp_req = flow_enabled && in_win;
  assign drain_ok = !vblank_only || (32'(y_vga) >= V_PIXELS);
  assign rd_addr  = ADDR_W'((32'(y_vga) - Y_OFF) * IMG_W + (32'(x_vga) - X_OFF));

  assign wr_ready = !fifo_full && !reset;
  assign push     = wr_valid && wr_ready;
  assign pop      = !disp_req && drain_ok && !fifo_empty;

  wr_fifo #(
    .Width (EntW),
    .Depth (WQ_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    if (disp_req) begin
      mem_addr_d = rd_addr;
    end else if (pop) begin
      mem_addr_d  = fifo_head[EntW-1:PIX_W];
      mem_wdata_d = fifo_head[PIX_W-1:0];
      mem_we_d    = 1'b1;
    end
    // Stage-2 flags line up with mem_rdata for the request made two cycles earlier.
    pixel_d = '0;
    if (de_q[1]) pixel_d = win_q[1] ? mem_rdata : BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      pixel_q     <= '0;
      hs_q        <= '1;
      vs_q        <= '1;
      de_q        <= '0;
      win_q       <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      pixel_q     <= pixel_d;
      hs_q        <= {hs_q[1:0], hsync};
      vs_q        <= {vs_q[1:0], vsync};
      de_q        <= {de_q[1:0], flow_enabled};
      win_q       <= {win_q[0], in_win};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (fifo_count <= CntW'(WQ_DEPTH));
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign pixel_out = pixel_q;
  assign hsync_out = hs_q[2];
  assign vsync_out = vs_q[2];
  assign de_out    = de_q[2];

endmodule
